// File: rtl/bank_arb_pkg.sv
// -----------------------------------------------------------------------------
// bank_arb_pkg
// Shared definitions for the four-bank access arbiter:
//   - state_t      : sequencer states (IDLE, ISSUE, RDATA)
//   - NUM_BANKS    : number of memory banks behind the demux
//   - BANK_SEL_W   : width of the bank-select field (top address bits)
//   - bank_of()    : extracts the bank field from a requester address
// -----------------------------------------------------------------------------
package bank_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    localparam int NUM_BANKS  = 4;
    localparam int BANK_SEL_W = 2;

    // The bank lives in the top BANK_SEL_W bits of an addr_w-wide address.
    // The address is passed zero-extended to 32 bits so one helper serves
    // any requester address width.
    function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [31:0] addr,
                                                      input int          addr_w);
        return BANK_SEL_W'(addr >> (addr_w - BANK_SEL_W));
    endfunction

endpackage

// File: rtl/bank_access_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick over N request lines. The search starts at
// i_ptr and wraps modulo N, so the requester at i_ptr has highest priority.
// Ports:
//   i_req    [N]      request vector
//   i_ptr    [PTR_W]  first index to consider (0..N-1)
//   o_onehot [N]      one-hot winner (all zero when nothing requests)
//   o_idx    [PTR_W]  binary index of the winner
//   o_valid           at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin : p_pick
        int               w_pos;
        logic [PTR_W-1:0] w_cand;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_pos    = 0;
        w_cand   = '0;
        for (int i = 0; i < N; i++) begin
            // Candidate index ptr+i, wrapped back into 0..N-1.
            w_pos = int'(i_ptr) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_cand = PTR_W'(w_pos);
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/bank_access_arbiter.sv
// -----------------------------------------------------------------------------
// bank_access_arbiter
// Round-robin arbiter and access sequencer for the four-bank memory. One
// access is serialised at a time: IDLE picks a winner and latches its
// command, ISSUE drives the bank demux for exactly one cycle, and RDATA
// (reads only) captures the returned data, which is presented with a
// one-cycle o_rvalid pulse while the sequencer is back in IDLE.
//
// Handshake: a requester holds i_req until it sees its o_gnt pulse; it drops
// i_req in the following cycle or keeps it high to queue another access.
// Requests are only sampled in IDLE; changes while busy are not seen.
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge), async active-low reset
//   i_req/i_we [NUM_REQ]   per-requester request level and write flag
//   i_addr, i_wdata        packed per-requester address / write data
//   o_gnt      [NUM_REQ]   one-hot grant pulse (ISSUE cycle)
//   o_rvalid   [NUM_REQ]   one-hot read-data-valid pulse
//   o_rdata    [DATA_W]    read data, valid with o_rvalid
//   o_busy                 sequencer not in IDLE
//   o_en, o_bank_sel       bank demux enable and select
//   o_mem_we, o_mem_addr,
//   o_mem_wdata            shared bank write-enable / address / data
//   i_mem_rdata [DATA_W]   muxed bank read data, valid the cycle after o_en
// -----------------------------------------------------------------------------
module bank_access_arbiter
    import bank_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_busy,
    output logic                      o_en,
    output logic [BANK_SEL_W-1:0]     o_bank_sel,
    output logic                      o_mem_we,
    output logic [ADDR_W-3:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_win_idx;
    logic [NUM_REQ-1:0]   r_win_oh;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [NUM_REQ-1:0]   r_rvalid;
    logic [DATA_W-1:0]    r_rdata;

    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [PTR_W-1:0]     w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_accept;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    assign w_accept = (r_state == ST_IDLE) && w_pick_valid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state and ISSUE-cycle strobes ----------------
    always_comb begin
        w_state_nxt = r_state;
        o_en        = 1'b0;
        o_mem_we    = 1'b0;
        o_gnt       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_en        = 1'b1;
                o_mem_we    = r_we;
                o_gnt       = r_win_oh;
                w_state_nxt = r_we ? ST_IDLE : ST_RDATA;
            end
            ST_RDATA: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- command latch, pointer, read return ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr     <= '0;
            r_win_idx <= '0;
            r_win_oh  <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rvalid  <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_win_idx <= w_pick_idx;
                r_win_oh  <= w_pick_oh;
                r_we      <= i_we[w_pick_idx];
                r_addr    <= i_addr[w_pick_idx*ADDR_W +: ADDR_W];
                r_wdata   <= i_wdata[w_pick_idx*DATA_W +: DATA_W];
            end
            // The winner just granted becomes lowest priority next time.
            if (r_state == ST_ISSUE) begin
                r_ptr <= (r_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_win_idx + 1'b1;
            end
            r_rvalid <= '0;
            if (r_state == ST_RDATA) begin
                r_rvalid <= r_win_oh;
                r_rdata  <= i_mem_rdata;
            end
        end
    end

    // Address/data lines come straight from the latch, so they naturally
    // hold their last issued values outside ISSUE.
    assign o_bank_sel  = bank_of(32'(r_addr), ADDR_W);
    assign o_mem_addr  = r_addr[ADDR_W-3:0];
    assign o_mem_wdata = r_wdata;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_rvalid    = r_rvalid;
    assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_bank_access_arbiter.sv
module tb_bank_access_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;

    logic                      i_clk;
    logic                      i_rst_n;
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ-1:0]        i_we;
    logic [NUM_REQ*ADDR_W-1:0] i_addr;
    logic [NUM_REQ*DATA_W-1:0] i_wdata;
    logic [NUM_REQ-1:0]        o_gnt;
    logic [NUM_REQ-1:0]        o_rvalid;
    logic [DATA_W-1:0]         o_rdata;
    logic                      o_busy;
    logic                      o_en;
    logic [1:0]                o_bank_sel;
    logic                      o_mem_we;
    logic [ADDR_W-3:0]         o_mem_addr;
    logic [DATA_W-1:0]         o_mem_wdata;
    logic [DATA_W-1:0]         i_mem_rdata;

    logic [DATA_W-1:0]         mem_ret;
    int                        n_tests;
    int                        n_fail;

    bank_access_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_gnt       (o_gnt),
        .o_rvalid    (o_rvalid),
        .o_rdata     (o_rdata),
        .o_busy      (o_busy),
        .o_en        (o_en),
        .o_bank_sel  (o_bank_sel),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Bank model: a read enabled in one cycle returns mem_ret in the next.
    always @(posedge i_clk) begin
        i_mem_rdata <= (o_en && !o_mem_we) ? mem_ret : '0;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_cmd(input int k, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata);
        i_we[k]              = we;
        i_addr[k*ADDR_W +: ADDR_W]  = addr;
        i_wdata[k*DATA_W +: DATA_W] = wdata;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    32'(o_gnt),       32'h0);
        check({tag, "_rvalid"}, 32'(o_rvalid),    32'h0);
        check({tag, "_rdata"},  32'(o_rdata),     32'h0);
        check({tag, "_busy"},   32'(o_busy),      32'h0);
        check({tag, "_en"},     32'(o_en),        32'h0);
        check({tag, "_sel"},    32'(o_bank_sel),  32'h0);
        check({tag, "_we"},     32'(o_mem_we),    32'h0);
        check({tag, "_maddr"},  32'(o_mem_addr),  32'h0);
        check({tag, "_mwdata"}, 32'(o_mem_wdata), 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        mem_ret = 8'h00;
        i_rst_n = 1'b0;
        i_req   = '0;
        i_we    = '0;
        i_addr  = '0;
        i_wdata = '0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        i_rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(o_busy), 32'h0);

        // Single write: req0, addr C5, data 3A (ptr 0)
        set_cmd(0, 1'b1, 8'hC5, 8'h3A);
        i_req = 4'b0001;
        tick();
        check("wr_gnt",    32'(o_gnt),       32'h1);
        check("wr_en",     32'(o_en),        32'h1);
        check("wr_sel",    32'(o_bank_sel),  32'h3);
        check("wr_maddr",  32'(o_mem_addr),  32'h05);
        check("wr_mwdata", 32'(o_mem_wdata), 32'h3A);
        check("wr_we",     32'(o_mem_we),    32'h1);
        check("wr_busy",   32'(o_busy),      32'h1);
        i_req = 4'b0000;
        tick();
        check("wr_idle_en",   32'(o_en),       32'h0);
        check("wr_idle_gnt",  32'(o_gnt),      32'h0);
        check("wr_idle_we",   32'(o_mem_we),   32'h0);
        check("wr_idle_busy", 32'(o_busy),     32'h0);
        check("wr_hold_sel",  32'(o_bank_sel), 32'h3);
        check("wr_rvalid",    32'(o_rvalid),   32'h0);
        tick();
        check("wr_rvalid2",   32'(o_rvalid),   32'h0);

        // Single read: req2, addr 47, memory returns 9E (ptr 1)
        mem_ret = 8'h9E;
        set_cmd(2, 1'b0, 8'h47, 8'h00);
        i_req = 4'b0100;
        tick();
        check("rd_gnt",   32'(o_gnt),      32'h4);
        check("rd_sel",   32'(o_bank_sel), 32'h1);
        check("rd_maddr", 32'(o_mem_addr), 32'h07);
        check("rd_we",    32'(o_mem_we),   32'h0);
        check("rd_en",    32'(o_en),       32'h1);
        i_req = 4'b0000;
        tick();
        check("rd_rdata_en",   32'(o_en),     32'h0);
        check("rd_rdata_busy", 32'(o_busy),   32'h1);
        check("rd_rdata_rv",   32'(o_rvalid), 32'h0);
        tick();
        check("rd_rvalid", 32'(o_rvalid), 32'h4);
        check("rd_rdata",  32'(o_rdata),  32'h9E);
        check("rd_busy",   32'(o_busy),   32'h0);
        tick();
        check("rd_rvalid_pulse", 32'(o_rvalid), 32'h0);
        check("rd_rdata_hold",   32'(o_rdata),  32'h9E);

        // Round-robin fairness from reset: all four hold reads
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        mem_ret = 8'h55;
        for (int k = 0; k < NUM_REQ; k++) begin
            set_cmd(k, 1'b0, 8'(8'h10 * k + 1), 8'h00);
        end
        i_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_gnt",      32'(o_gnt),    32'(1) << (g % 4));
            tick();
            check("rr_gap_gnt",  32'(o_gnt),    32'h0);
            tick();
            check("rr_gap2_gnt", 32'(o_gnt),    32'h0);
            check("rr_rvalid",   32'(o_rvalid), 32'(1) << (g % 4));
            check("rr_rdata",    32'(o_rdata),  32'h55);
        end
        i_req = 4'b0000;
        tick();

        // Pointer effect: grant req1, then req0+req3 -> req3 first
        set_cmd(1, 1'b1, 8'h20, 8'h11);
        i_req = 4'b0010;
        tick();
        check("ptr_gnt1", 32'(o_gnt), 32'h2);
        i_req = 4'b0000;
        tick();
        set_cmd(0, 1'b1, 8'h01, 8'h22);
        set_cmd(3, 1'b1, 8'h83, 8'h33);
        i_req = 4'b1001;
        tick();
        check("ptr_gnt3",   32'(o_gnt),       32'h8);
        check("ptr_sel3",   32'(o_bank_sel),  32'h2);
        check("ptr_wdata3", 32'(o_mem_wdata), 32'h33);
        i_req = 4'b0001;
        tick();
        check("ptr_idle_gnt", 32'(o_gnt), 32'h0);
        tick();
        check("ptr_gnt0",   32'(o_gnt),       32'h1);
        check("ptr_wdata0", 32'(o_mem_wdata), 32'h22);
        i_req = 4'b0000;
        tick();

        // Reset during RDATA: read by req0 (ptr 1, only req0 asks)
        mem_ret = 8'h77;
        set_cmd(0, 1'b0, 8'h8A, 8'h00);
        i_req = 4'b0001;
        tick();
        check("rst_rd_gnt", 32'(o_gnt), 32'h1);
        tick();
        check("rst_in_rdata", 32'(o_busy), 32'h1);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        tick();
        check("rst_no_rvalid", 32'(o_rvalid), 32'h0);
        check("rst_busy",      32'(o_busy),   32'h0);
        // ptr must be back at 0: req0 beats req1
        i_rst_n = 1'b1;
        set_cmd(0, 1'b1, 8'h01, 8'h44);
        set_cmd(1, 1'b1, 8'h02, 8'h66);
        i_req = 4'b0011;
        tick();
        check("rst_regnt0", 32'(o_gnt), 32'h1);
        check("rst_rvalid", 32'(o_rvalid), 32'h0);
        i_req = 4'b0010;
        tick();
        tick();
        check("rst_regnt1", 32'(o_gnt), 32'h2);
        i_req = 4'b0000;
        tick();

        // Back-to-back writes by req1: addr 00 then FF
        set_cmd(1, 1'b1, 8'h00, 8'hAB);
        i_req = 4'b0010;
        tick();
        check("b2b_gnt_a",  32'(o_gnt),      32'h2);
        check("b2b_sel_a",  32'(o_bank_sel), 32'h0);
        check("b2b_busy_a", 32'(o_busy),     32'h1);
        set_cmd(1, 1'b1, 8'hFF, 8'hCD);
        #1;
        check("b2b_ignore_chg", 32'(o_bank_sel), 32'h0);
        tick();
        check("b2b_idle_busy", 32'(o_busy), 32'h0);
        check("b2b_idle_en",   32'(o_en),   32'h0);
        tick();
        check("b2b_gnt_b",    32'(o_gnt),       32'h2);
        check("b2b_sel_b",    32'(o_bank_sel),  32'h3);
        check("b2b_maddr_b",  32'(o_mem_addr),  32'h3F);
        check("b2b_mwdata_b", 32'(o_mem_wdata), 32'hCD);
        check("b2b_busy_b",   32'(o_busy),      32'h1);
        i_req = 4'b0000;
        tick();
        check("b2b_end_busy", 32'(o_busy),     32'h0);
        check("b2b_end_sel",  32'(o_bank_sel), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
